// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: RV32 opcode/funct fields,
// widened alu_op codes and the sequencer state encoding.
package alu_ctrl_pkg;

    localparam int OP_CODE_W = 5;
    typedef logic [OP_CODE_W-1:0] op_code_t;

    localparam logic [6:0] LOAD           = 7'b0000011;
    localparam logic [6:0] STORE          = 7'b0100011;
    localparam logic [6:0] JALR           = 7'b1100111;
    localparam logic [6:0] BRANCH         = 7'b1100011;
    localparam logic [6:0] ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam op_code_t OP_ADD      = 5'd0;
    localparam op_code_t OP_SUB      = 5'd1;
    localparam op_code_t OP_SLL      = 5'd2;
    localparam op_code_t OP_SLT      = 5'd3;
    localparam op_code_t OP_SLTU     = 5'd4;
    localparam op_code_t OP_XOR      = 5'd5;
    localparam op_code_t OP_SRL      = 5'd6;
    localparam op_code_t OP_SRA      = 5'd7;
    localparam op_code_t OP_OR       = 5'd8;
    localparam op_code_t OP_AND      = 5'd9;
    localparam op_code_t OP_SUB_BEQ  = 5'd10;
    localparam op_code_t OP_SUB_BNE  = 5'd11;
    localparam op_code_t OP_SUB_BLT  = 5'd12;
    localparam op_code_t OP_SUB_BGE  = 5'd13;
    localparam op_code_t OP_SUB_BLTU = 5'd14;
    localparam op_code_t OP_SUB_BGEU = 5'd15;
    localparam op_code_t OP_MUL      = 5'd16;
    localparam op_code_t OP_MULH     = 5'd17;
    localparam op_code_t OP_MULHSU   = 5'd18;
    localparam op_code_t OP_MULHU    = 5'd19;
    localparam op_code_t OP_DIV      = 5'd20;
    localparam op_code_t OP_DIVU     = 5'd21;
    localparam op_code_t OP_REM      = 5'd22;
    localparam op_code_t OP_REMU     = 5'd23;
    localparam op_code_t OP_DEFAULT  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    // Base integer op selected by funct3 (SUB/SRA variants handled by the caller).
    function automatic op_code_t base_op(input logic [2:0] f3);
        case (f3)
            FUNCT3_ADD_SUB: return OP_ADD;
            FUNCT3_SLL:     return OP_SLL;
            FUNCT3_SLT:     return OP_SLT;
            FUNCT3_SLTU:    return OP_SLTU;
            FUNCT3_XOR:     return OP_XOR;
            FUNCT3_SRL_SRA: return OP_SRL;
            FUNCT3_OR:      return OP_OR;
            default:        return OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Decode-side and EX-side handshake bundle of the ALU control sequencer.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready; valid
// must not wait for ready, and the producer holds its payload until the transfer.
interface alu_control_seq_if #(
    parameter int OP_W = 5
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [1:0]      alu_op_sig;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] alu_op;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, inst, alu_op_sig, out_ready,
        input  in_ready, out_valid, alu_op, illegal, busy
    );

    modport slave (
        input  in_valid, inst, alu_op_sig, out_ready,
        output in_ready, out_valid, alu_op, illegal, busy
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I(+M) ALU op decoder; alu_op_sig overrides the instruction.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] inst,
    input  logic [1:0]  alu_op_sig,
    output op_code_t    alu_op,
    output logic        illegal,
    output logic        is_mul,
    output logic        is_div
);
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_fields;

    assign opcode        = inst[6:0];
    assign funct3        = inst[14:12];
    assign funct7        = inst[31:25];
    assign unused_fields = ^{inst[24:15], inst[11:7]};

    always_comb begin
        alu_op  = OP_DEFAULT;
        illegal = 1'b1;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (alu_op_sig)
            2'b00: begin alu_op = OP_ADD; illegal = 1'b0; end
            2'b10: begin alu_op = OP_SUB; illegal = 1'b0; end
            2'b01: begin
                case (opcode)
                    LOAD, STORE, JALR: begin
                        alu_op  = OP_ADD;
                        illegal = 1'b0;
                    end
                    BRANCH: begin
                        illegal = 1'b0;
                        case (funct3)
                            FUNCT3_BEQ:  alu_op = OP_SUB_BEQ;
                            FUNCT3_BNE:  alu_op = OP_SUB_BNE;
                            FUNCT3_BLT:  alu_op = OP_SUB_BLT;
                            FUNCT3_BGE:  alu_op = OP_SUB_BGE;
                            FUNCT3_BLTU: alu_op = OP_SUB_BLTU;
                            FUNCT3_BGEU: alu_op = OP_SUB_BGEU;
                            default:     illegal = 1'b1;
                        endcase
                    end
                    ARITHMETIC_IMM: begin
                        // Shift immediates carry a funct7 qualifier; the rest use imm[11:5] freely.
                        if (funct3 == FUNCT3_SLL) begin
                            if (funct7 == FUNCT7_BASE) begin
                                alu_op  = OP_SLL;
                                illegal = 1'b0;
                            end
                        end else if (funct3 == FUNCT3_SRL_SRA) begin
                            if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) begin
                                alu_op  = inst[30] ? OP_SRA : OP_SRL;
                                illegal = 1'b0;
                            end
                        end else begin
                            alu_op  = base_op(funct3);
                            illegal = 1'b0;
                        end
                    end
                    ARITHMETIC: begin
                        if (funct7 == FUNCT7_BASE) begin
                            alu_op  = base_op(funct3);
                            illegal = 1'b0;
                        end else if (funct7 == FUNCT7_ALT) begin
                            if (funct3 == FUNCT3_ADD_SUB) begin
                                alu_op  = OP_SUB;
                                illegal = 1'b0;
                            end else if (funct3 == FUNCT3_SRL_SRA) begin
                                alu_op  = OP_SRA;
                                illegal = 1'b0;
                            end
                        end else if (funct7 == FUNCT7_MULDIV && ENABLE_M) begin
                            // M ops are laid out contiguously from OP_MUL in funct3 order.
                            alu_op  = OP_MUL + op_code_t'(funct3);
                            illegal = 1'b0;
                            is_mul  = !funct3[2];
                            is_div  = funct3[2];
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: registers the decoded op behind a valid/ready handshake
// and stalls upstream while a multi-cycle MUL/DIV occupies the EX datapath.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W        = 5,
    parameter bit ENABLE_M    = 1'b1,
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    alu_control_seq_if.slave  bus,
    output state_t            state_dbg
);
    localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [OP_W-1:0] alu_op_q;
    logic            illegal_q;

    op_code_t        dec_op;
    logic            dec_illegal;
    logic            dec_is_mul;
    logic            dec_is_div;
    logic [5:0]      load_cnt;
    logic            in_ready;
    logic            accept;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .inst       (bus.inst),
        .alu_op_sig (bus.alu_op_sig),
        .alu_op     (dec_op),
        .illegal    (dec_illegal),
        .is_mul     (dec_is_mul),
        .is_div     (dec_is_div)
    );

    always_comb begin
        load_cnt = 6'd0;
        if (dec_is_mul)      load_cnt = MUL_CNT;
        else if (dec_is_div) load_cnt = DIV_CNT;
    end

    assign in_ready = !flush && (state_q == ST_IDLE || (state_q == ST_HOLD && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
        end else if (accept) begin
            // A latency of 1 loads zero and goes straight to HOLD like any single-cycle op.
            state_d = (load_cnt != 6'd0) ? ST_BUSY : ST_HOLD;
            cnt_d   = load_cnt;
        end else begin
            case (state_q)
                ST_HOLD: if (bus.out_ready) state_d = ST_IDLE;
                ST_BUSY: begin
                    if (cnt_q <= 6'd1) begin
                        state_d = ST_HOLD;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            alu_op_q  <= OP_W'(OP_DEFAULT);
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                alu_op_q  <= OP_W'(dec_op);
                illegal_q <= dec_illegal;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q == ST_BUSY);
    assign bus.alu_op    = alu_op_q;
    assign bus.illegal   = illegal_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table, handshake, latency, flush, reset.
module tb_alu_control_seq;
    import alu_ctrl_pkg::*;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   flush = 1'b0;
    logic   flush_nm = 1'b0;
    state_t state_dbg, state_dbg_nm;
    int     tests_run = 0;
    int     tests_failed = 0;

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_SUB = 32'h403100B3;
    localparam logic [31:0] I_MUL = 32'h023100B3;
    localparam logic [31:0] I_DIV = 32'h023140B3;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_XOR = 32'h003140B3;

    alu_control_seq_if #(.OP_W(5)) bus ();
    alu_control_seq_if #(.OP_W(5)) bus_nm ();

    alu_control_seq #(.OP_W(5), .ENABLE_M(1'b1), .MUL_LATENCY(3), .DIV_LATENCY(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus.slave), .state_dbg(state_dbg)
    );

    alu_control_seq #(.OP_W(5), .ENABLE_M(1'b0), .MUL_LATENCY(3), .DIV_LATENCY(32)) dut_nm (
        .clk(clk), .reset(reset), .flush(flush_nm), .bus(bus_nm.slave), .state_dbg(state_dbg_nm)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive_idle;
        bus.in_valid = 1'b0;  bus.inst = 32'h0;  bus.alu_op_sig = 2'b01;  bus.out_ready = 1'b1;
        bus_nm.in_valid = 1'b0;  bus_nm.inst = 32'h0;  bus_nm.alu_op_sig = 2'b01;  bus_nm.out_ready = 1'b1;
        flush = 1'b0;  flush_nm = 1'b0;
    endtask

    task automatic send(input logic [31:0] inst, input logic [1:0] sig);
        bus.in_valid = 1'b1;  bus.inst = inst;  bus.alu_op_sig = sig;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    task automatic test_reset;
        #1;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        tests_run++; if (bus.alu_op !== OP_DEFAULT) begin tests_failed++; $display("FAIL reset_alu_op: got %0d want %0d", bus.alu_op, OP_DEFAULT); end
        tests_run++; if (bus.illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal: got %0b want 0", bus.illegal); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        tests_run++; if (state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    endtask

    task automatic test_back_to_back;
        send(I_ADD, 2'b01);  #1;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready0: got %0b want 1", bus.in_ready); end
        tick;  send(I_SUB, 2'b01);  #1;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.alu_op !== OP_ADD) begin tests_failed++; $display("FAIL b2b_add: got v=%0b op=%0d want v=1 op=%0d", bus.out_valid, bus.alu_op, OP_ADD); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready1: got %0b want 1", bus.in_ready); end
        tick;  bus.in_valid = 1'b0;  #1;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.alu_op !== OP_SUB) begin tests_failed++; $display("FAIL b2b_sub: got v=%0b op=%0d want v=1 op=%0d", bus.out_valid, bus.alu_op, OP_SUB); end
        tick;  #1;
        tests_run++; if (bus.out_valid !== 1'b0 || bus.alu_op !== OP_SUB || state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL b2b_idle: got v=%0b op=%0d st=%0d want v=0 op=%0d idle", bus.out_valid, bus.alu_op, state_dbg, OP_SUB); end
    endtask

    task automatic test_decode_table;
        logic [31:0] tv_inst [16];
        logic [1:0]  tv_sig  [16];
        op_code_t    tv_op   [16];
        logic        tv_ill  [16];
        tv_inst[0]  = mk(7'b0000000, 3'b001, 7'b0110011); tv_sig[0]  = 2'b01; tv_op[0]  = OP_SLL;      tv_ill[0]  = 1'b0;
        tv_inst[1]  = mk(7'b0000000, 3'b011, 7'b0110011); tv_sig[1]  = 2'b01; tv_op[1]  = OP_SLTU;     tv_ill[1]  = 1'b0;
        tv_inst[2]  = mk(7'b0100000, 3'b101, 7'b0110011); tv_sig[2]  = 2'b01; tv_op[2]  = OP_SRA;      tv_ill[2]  = 1'b0;
        tv_inst[3]  = mk(7'b0100000, 3'b001, 7'b0110011); tv_sig[3]  = 2'b01; tv_op[3]  = OP_DEFAULT;  tv_ill[3]  = 1'b1;
        tv_inst[4]  = mk(7'b0100000, 3'b101, 7'b0010011); tv_sig[4]  = 2'b01; tv_op[4]  = OP_SRA;      tv_ill[4]  = 1'b0;
        tv_inst[5]  = mk(7'b0000001, 3'b101, 7'b0010011); tv_sig[5]  = 2'b01; tv_op[5]  = OP_DEFAULT;  tv_ill[5]  = 1'b1;
        tv_inst[6]  = mk(7'b1111111, 3'b111, 7'b0010011); tv_sig[6]  = 2'b01; tv_op[6]  = OP_AND;      tv_ill[6]  = 1'b0;
        tv_inst[7]  = mk(7'b0000000, 3'b111, 7'b1100011); tv_sig[7]  = 2'b01; tv_op[7]  = OP_SUB_BGEU; tv_ill[7]  = 1'b0;
        tv_inst[8]  = mk(7'b0000000, 3'b010, 7'b1100011); tv_sig[8]  = 2'b01; tv_op[8]  = OP_DEFAULT;  tv_ill[8]  = 1'b1;
        tv_inst[9]  = mk(7'b0000000, 3'b010, 7'b0000011); tv_sig[9]  = 2'b01; tv_op[9]  = OP_ADD;      tv_ill[9]  = 1'b0;
        tv_inst[10] = mk(7'b0000000, 3'b010, 7'b0100011); tv_sig[10] = 2'b01; tv_op[10] = OP_ADD;      tv_ill[10] = 1'b0;
        tv_inst[11] = mk(7'b0000000, 3'b000, 7'b0110111); tv_sig[11] = 2'b01; tv_op[11] = OP_DEFAULT;  tv_ill[11] = 1'b1;
        tv_inst[12] = I_ADD;                              tv_sig[12] = 2'b11; tv_op[12] = OP_DEFAULT;  tv_ill[12] = 1'b1;
        tv_inst[13] = mk(7'b0000000, 3'b111, 7'b0110011); tv_sig[13] = 2'b10; tv_op[13] = OP_SUB;      tv_ill[13] = 1'b0;
        tv_inst[14] = mk(7'b0000000, 3'b001, 7'b0010011); tv_sig[14] = 2'b01; tv_op[14] = OP_SLL;      tv_ill[14] = 1'b0;
        tv_inst[15] = mk(7'b0000000, 3'b100, 7'b1100011); tv_sig[15] = 2'b01; tv_op[15] = OP_SUB_BLT;  tv_ill[15] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(tv_inst[i], tv_sig[i]);
            tick;  #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.alu_op !== tv_op[i] || bus.illegal !== tv_ill[i]) begin
                tests_failed++;
                $display("FAIL decode_%0d: got v=%0b op=%0d ill=%0b want v=1 op=%0d ill=%0b", i, bus.out_valid, bus.alu_op, bus.illegal, tv_op[i], tv_ill[i]);
            end
        end
        bus.in_valid = 1'b0;
        tick;
    endtask

    task automatic test_mul;
        send(I_MUL, 2'b01);  #1;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL mul_accept_ready: got %0b want 1", bus.in_ready); end
        tick;  send(I_ADD, 2'b01);  #1;
        for (int c = 1; c <= 2; c++) begin
            tests_run++;
            if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.alu_op !== OP_MUL) begin
                tests_failed++;
                $display("FAIL mul_cycle%0d: got busy=%0b v=%0b rdy=%0b op=%0d want busy=1 v=0 rdy=0 op=%0d", c, bus.busy, bus.out_valid, bus.in_ready, bus.alu_op, OP_MUL);
            end
            tick;  #1;
        end
        tests_run++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b1 || bus.alu_op !== OP_MUL || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL mul_cycle3: got busy=%0b v=%0b op=%0d rdy=%0b want busy=0 v=1 op=%0d rdy=1", bus.busy, bus.out_valid, bus.alu_op, bus.in_ready, OP_MUL); end
        tick;  bus.in_valid = 1'b0;  #1;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.alu_op !== OP_ADD) begin tests_failed++; $display("FAIL mul_next_add: got v=%0b op=%0d want v=1 op=%0d", bus.out_valid, bus.alu_op, OP_ADD); end
        tick;
    endtask

    task automatic test_backpressure;
        send(I_BEQ, 2'b01);
        tick;  send(I_ADD, 2'b01);  bus.out_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.alu_op !== OP_SUB_BEQ || bus.illegal !== 1'b0 || bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_cycle%0d: got v=%0b op=%0d ill=%0b rdy=%0b want v=1 op=%0d ill=0 rdy=0", c, bus.out_valid, bus.alu_op, bus.illegal, bus.in_ready, OP_SUB_BEQ);
            end
            tick;
        end
        bus.out_ready = 1'b1;  bus.in_valid = 1'b0;  #1;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.alu_op !== OP_SUB_BEQ) begin tests_failed++; $display("FAIL bp_cycle4: got v=%0b op=%0d want v=1 op=%0d", bus.out_valid, bus.alu_op, OP_SUB_BEQ); end
        tick;  #1;
        tests_run++; if (bus.out_valid !== 1'b0 || state_dbg !== ST_IDLE || bus.alu_op !== OP_SUB_BEQ) begin tests_failed++; $display("FAIL bp_idle: got v=%0b st=%0d op=%0d want v=0 idle op=%0d", bus.out_valid, state_dbg, bus.alu_op, OP_SUB_BEQ); end
    endtask

    task automatic test_div_flush;
        logic seen = 1'b0;
        tick;  send(I_DIV, 2'b01);
        tick;  bus.in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) flush = 1'b1;
            #1;
            tests_run++;
            if (bus.busy !== 1'b1 || bus.alu_op !== OP_DIV || (c == 5 && bus.in_ready !== 1'b0)) begin
                tests_failed++;
                $display("FAIL div_cycle%0d: got busy=%0b op=%0d rdy=%0b want busy=1 op=%0d", c, bus.busy, bus.alu_op, bus.in_ready, OP_DIV);
            end
            tick;
        end
        flush = 1'b0;  #1;
        tests_run++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL div_flushed: got busy=%0b v=%0b st=%0d want busy=0 v=0 idle", bus.busy, bus.out_valid, state_dbg); end
        for (int c = 6; c <= 40; c++) begin
            if (bus.out_valid !== 1'b0) seen = 1'b1;
            tick;  #1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL div_no_result: got out_valid seen=1 want 0"); end
        send(I_ADD, 2'b01);  #1;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL div_after_ready: got %0b want 1", bus.in_ready); end
        tick;  bus.in_valid = 1'b0;  #1;
        tests_run++; if (bus.out_valid !== 1'b1 || bus.alu_op !== OP_ADD) begin tests_failed++; $display("FAIL div_after_add: got v=%0b op=%0d want v=1 op=%0d", bus.out_valid, bus.alu_op, OP_ADD); end
        tick;
    endtask

    task automatic test_flush_hold;
        send(I_XOR, 2'b01);
        tick;  send(I_SUB, 2'b01);  flush = 1'b1;  #1;
        tests_run++; if (bus.in_ready !== 1'b0 || bus.alu_op !== OP_XOR) begin tests_failed++; $display("FAIL fh_ready: got rdy=%0b op=%0d want rdy=0 op=%0d", bus.in_ready, bus.alu_op, OP_XOR); end
        tick;  flush = 1'b0;  bus.in_valid = 1'b0;  #1;
        tests_run++; if (bus.out_valid !== 1'b0 || state_dbg !== ST_IDLE || bus.alu_op !== OP_XOR) begin tests_failed++; $display("FAIL fh_idle: got v=%0b st=%0d op=%0d want v=0 idle op=%0d", bus.out_valid, state_dbg, bus.alu_op, OP_XOR); end
    endtask

    task automatic test_enable_m_off;
        tick;
        bus_nm.in_valid = 1'b1;  bus_nm.inst = I_MUL;  bus_nm.alu_op_sig = 2'b01;
        tick;  bus_nm.alu_op_sig = 2'b00;  #1;
        tests_run++; if (bus_nm.alu_op !== OP_DEFAULT || bus_nm.illegal !== 1'b1 || bus_nm.busy !== 1'b0 || bus_nm.out_valid !== 1'b1) begin tests_failed++; $display("FAIL nom_mul: got op=%0d ill=%0b busy=%0b v=%0b want op=%0d ill=1 busy=0 v=1", bus_nm.alu_op, bus_nm.illegal, bus_nm.busy, bus_nm.out_valid, OP_DEFAULT); end
        tick;  bus_nm.in_valid = 1'b0;  #1;
        tests_run++; if (bus_nm.alu_op !== OP_ADD || bus_nm.illegal !== 1'b0 || bus_nm.out_valid !== 1'b1) begin tests_failed++; $display("FAIL nom_force_add: got op=%0d ill=%0b v=%0b want op=%0d ill=0 v=1", bus_nm.alu_op, bus_nm.illegal, bus_nm.out_valid, OP_ADD); end
        tick;
    endtask

    task automatic test_reset_busy;
        logic seen = 1'b0;
        send(I_DIV, 2'b01);
        tick;  bus.in_valid = 1'b0;
        tick;  tick;  #1;
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL rb_busy: got %0b want 1", bus.busy); end
        #1;  reset = 1'b1;  #1;
        tests_run++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.alu_op !== OP_DEFAULT || state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL rb_async: got v=%0b busy=%0b op=%0d st=%0d want v=0 busy=0 op=%0d idle", bus.out_valid, bus.busy, bus.alu_op, state_dbg, OP_DEFAULT); end
        tick;  reset = 1'b0;  #1;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rb_ready: got %0b want 1", bus.in_ready); end
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
            tick;  #1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL rb_stale: got stale result/busy after reset want none"); end
    endtask

    initial begin
        drive_idle;
        reset = 1'b1;
        tick;  tick;
        reset = 1'b0;
        test_reset;
        tick;
        test_back_to_back;
        test_decode_table;
        test_mul;
        test_backpressure;
        test_div_flush;
        test_flush_hold;
        test_enable_m_off;
        test_reset_busy;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
